// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shift/rotate unit: mode encodings and a
// plain-arithmetic reference function for results and carry.
package shifter_pkg;

  localparam logic [2:0] SHIFT_SLL = 3'b000;
  localparam logic [2:0] SHIFT_SRL = 3'b001;
  localparam logic [2:0] SHIFT_SRA = 3'b010;
  localparam logic [2:0] SHIFT_ROL = 3'b011;
  localparam logic [2:0] SHIFT_ROR = 3'b100;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic                 carry;
  } shift_res_t;

  // Bit-by-bit definition of every mode; width may be anything up to MAX_WIDTH.
  function automatic shift_res_t shift_ref(input logic [MAX_WIDTH-1:0] d,
                                           input int width,
                                           input int n,
                                           input logic [2:0] mode);
    shift_res_t r;
    r.data  = '0;
    r.carry = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        case (mode)
          SHIFT_SLL: r.data[i] = (i >= n) ? d[i-n] : 1'b0;
          SHIFT_SRL: r.data[i] = (i + n < width) ? d[i+n] : 1'b0;
          SHIFT_SRA: r.data[i] = (i + n < width) ? d[i+n] : d[width-1];
          SHIFT_ROL: r.data[i] = d[(i - n + width) % width];
          SHIFT_ROR: r.data[i] = d[(i + n) % width];
          default:   r.data[i] = d[i];
        endcase
      end
    end
    if (n != 0) begin
      case (mode)
        SHIFT_SLL: r.carry = d[width-n];
        SHIFT_SRL: r.carry = d[n-1];
        SHIFT_SRA: r.carry = d[n-1];
        SHIFT_ROL: r.carry = r.data[0];
        SHIFT_ROR: r.carry = r.data[width-1];
        default:   r.carry = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_slice.sv
// One register slice of the shifter: applies mux levels LVL_LO..LVL_HI-1 and
// registers data, carry, mode, shift amount and valid under backpressure.
module shift_slice
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHW    = 5,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  input  logic [2:0]       mode_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o,
  output logic [2:0]       mode_o,
  output logic [SHW-1:0]   shamt_o
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [2:0]       mode_q;
  logic [SHW-1:0]   shamt_q;

  assign ready_o = !valid_q || ready_i;

  // Carry is the bit that crosses the word edge at the latest active level;
  // for rotates that bit is exactly the one landing in the far end of the result.
  always_comb begin
    data_d  = data_i;
    carry_d = carry_i;
    for (int j = LVL_LO; j < LVL_HI; j++) begin
      if (shamt_i[j]) begin
        case (mode_i)
          SHIFT_SLL: begin
            carry_d = |(data_d & (ONE_W << (WIDTH - (1 << j))));
            data_d  = data_d << (1 << j);
          end
          SHIFT_SRL: begin
            carry_d = |(data_d & (ONE_W << ((1 << j) - 1)));
            data_d  = data_d >> (1 << j);
          end
          SHIFT_SRA: begin
            carry_d = |(data_d & (ONE_W << ((1 << j) - 1)));
            data_d  = $signed(data_d) >>> (1 << j);
          end
          SHIFT_ROL: begin
            carry_d = |(data_d & (ONE_W << (WIDTH - (1 << j))));
            data_d  = (data_d << (1 << j)) | (data_d >> (WIDTH - (1 << j)));
          end
          SHIFT_ROR: begin
            carry_d = |(data_d & (ONE_W << ((1 << j) - 1)));
            data_d  = (data_d >> (1 << j)) | (data_d << (WIDTH - (1 << j)));
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q  <= data_d;
        carry_q <= carry_d;
        mode_q  <= mode_i;
        shamt_q <= shamt_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign carry_o = carry_q;
  assign mode_o  = mode_q;
  assign shamt_o = shamt_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit: a chain of LAT register slices, each covering
// REG_EVERY log-shifter levels, with full-throughput valid/ready flow control.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHW       = $clog2(WIDTH),
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       mode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic             carryOut
);

  localparam int LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

  // Handshake: a transfer happens on a rising edge where valid && ready. A
  // producer holds valid and its payload until that edge; ready never depends
  // on the valid it is paired with. Stage ready = !stage_valid || next_ready.
  logic             v_w [LAT+1];
  logic             r_w [LAT+1];
  logic [WIDTH-1:0] d_w [LAT+1];
  logic             c_w [LAT+1];
  logic [2:0]       m_w [LAT+1];
  logic [SHW-1:0]   s_w [LAT+1];

  // Holds off input acceptance until the first edge after reset release.
  logic rdy_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  assign v_w[0]   = inValid && rdy_en_q;
  assign d_w[0]   = dataIn;
  assign c_w[0]   = 1'b0;
  assign m_w[0]   = mode;
  assign s_w[0]   = shamt;
  assign r_w[LAT] = outReady;
  assign inReady  = rdy_en_q && r_w[0];

  for (genvar k = 0; k < LAT; k++) begin : g_slice
    localparam int LO = k * REG_EVERY;
    localparam int HI = ((k + 1) * REG_EVERY > SHW) ? SHW : (k + 1) * REG_EVERY;

    shift_slice #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .LVL_LO(LO),
      .LVL_HI(HI)
    ) u_slice (
      .clk    (clk),
      .rst    (rst),
      .valid_i(v_w[k]),
      .ready_o(r_w[k]),
      .data_i (d_w[k]),
      .carry_i(c_w[k]),
      .mode_i (m_w[k]),
      .shamt_i(s_w[k]),
      .valid_o(v_w[k+1]),
      .ready_i(r_w[k+1]),
      .data_o (d_w[k+1]),
      .carry_o(c_w[k+1]),
      .mode_o (m_w[k+1]),
      .shamt_o(s_w[k+1])
    );
  end

  assign outValid = v_w[LAT];
  assign dataOut  = d_w[LAT];
  assign carryOut = c_w[LAT];

  logic unused_tail;
  assign unused_tail = ^{m_w[LAT], s_w[LAT]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vectors with literal expectations plus a
// queue scoreboard fed by the shifter_pkg reference model.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int WIDTH     = 32;
  localparam int SHW       = 5;
  localparam int REG_EVERY = 2;
  localparam int LAT       = 3;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] dataIn;
  logic [SHW-1:0]   shamt;
  logic [2:0]       mode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] dataOut;
  logic             carryOut;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [WIDTH:0] exp_q[$];

  pipelined_shifter #(
    .WIDTH    (WIDTH),
    .REG_EVERY(REG_EVERY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .inReady (inReady),
    .dataIn  (dataIn),
    .shamt   (shamt),
    .mode    (mode),
    .outValid(outValid),
    .outReady(outReady),
    .dataOut (dataOut),
    .carryOut(carryOut)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [2:0] m, input logic [SHW-1:0] s,
                                           input logic [WIDTH-1:0] d);
    shift_res_t r;
    r = shift_ref(64'(d), WIDTH, int'(s), m);
    return {r.carry, r.data[WIDTH-1:0]};
  endfunction

  task automatic pin(input string name, input logic [2:0] m, input logic [SHW-1:0] s,
                     input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d, input logic exp_c);
    check(name, 64'(model(m, s, d)), 64'({exp_c, exp_d}));
  endtask

  // Single op on an empty pipe with outReady high; checks latency and literals.
  task automatic run_one(input string name, input logic [2:0] m, input logic [SHW-1:0] s,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d, input logic exp_c);
    int lat;
    outReady = 1'b1;
    mode     = m;
    shamt    = s;
    dataIn   = d;
    inValid  = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(inReady), 64'(1));
    step();
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(LAT));
    check({name, "_data"}, 64'(dataOut), 64'(exp_d));
    check({name, "_carry"}, 64'(carryOut), 64'(exp_c));
    step();
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (!rst) begin
      if (outValid) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("FAIL unexpected_result: got %h with carry %b, expected no output", dataOut, carryOut);
        end else begin
          check("sb_result", 64'({carryOut, dataOut}), 64'(exp_q[0]));
          if (outReady) void'(exp_q.pop_front());
        end
      end
      if (inValid && inReady) exp_q.push_back(model(mode, shamt, dataIn));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH:0] held;
    int idx, n_out, first_out, last_out, ops, waits;
    logic pending, stale;

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = '0;
    shamt    = '0;
    mode     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(outValid), 64'(0));
    check("rst_data_out", 64'(dataOut), 64'(0));
    check("rst_carry_out", 64'(carryOut), 64'(0));
    check("rst_in_ready", 64'(inReady), 64'(0));
    #2 rst = 1'b0;
    step();
    check("in_ready_after_rst", 64'(inReady), 64'(1));

    // Reference model pinned to hand-computed values.
    pin("pin_sra31", SHIFT_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    pin("pin_ror1",  SHIFT_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1);
    pin("pin_rol4",  SHIFT_ROL, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0);
    pin("pin_sll0",  SHIFT_SLL, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    pin("pin_srl5",  SHIFT_SRL, 5'd5,  32'h0000_00F0, 32'h0000_0007, 1'b1);
    pin("pin_pass",  3'b111,    5'd7,  32'h1234_5678, 32'h1234_5678, 1'b0);
    pin("pin_sll1",  SHIFT_SLL, 5'd1,  32'hC000_0000, 32'h8000_0000, 1'b1);
    pin("pin_sll31", SHIFT_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0);

    // Directed DUT vectors.
    run_one("sra31", SHIFT_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_one("ror1",  SHIFT_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1);
    run_one("rol4",  SHIFT_ROL, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0);
    run_one("sll0",  SHIFT_SLL, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_one("srl5",  SHIFT_SRL, 5'd5,  32'h0000_00F0, 32'h0000_0007, 1'b1);
    run_one("pass7", 3'b111,    5'd7,  32'h1234_5678, 32'h1234_5678, 1'b0);
    run_one("sll1",  SHIFT_SLL, 5'd1,  32'hC000_0000, 32'h8000_0000, 1'b1);
    run_one("pass5", 3'b101,    5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // Backpressure: 8 back-to-back ops against a stalled output.
    outReady = 1'b0;
    idx      = 0;
    held     = '0;
    for (int c = 0; c < 8; c++) begin
      mode    = 3'(idx % 5);
      shamt   = 5'(idx * 3 + 1);
      dataIn  = 32'h1000_0001 + 32'(idx);
      inValid = 1'b1;
      #1;
      if (inReady) idx++;
      if (c == 4) held = {carryOut, dataOut};
      step();
    end
    #1;
    check("bp_accepts", 64'(idx), 64'(LAT));
    check("bp_in_ready_low", 64'(inReady), 64'(0));
    check("bp_out_valid", 64'(outValid), 64'(1));
    check("bp_hold_stable", 64'({carryOut, dataOut}), 64'(held));
    outReady  = 1'b1;
    n_out     = 0;
    first_out = -1;
    last_out  = -1;
    for (int c = 0; c < 30 && n_out < 8; c++) begin
      if (idx < 8) begin
        mode    = 3'(idx % 5);
        shamt   = 5'(idx * 3 + 1);
        dataIn  = 32'h1000_0001 + 32'(idx);
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (inValid && inReady) idx++;
      if (outValid) begin
        n_out++;
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      step();
    end
    inValid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'(8));
    check("bp_results", 64'(n_out), 64'(8));
    check("bp_no_bubbles", 64'(last_out - first_out), 64'(7));

    // Asynchronous reset with two ops in flight.
    outReady = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mode    = SHIFT_ROL;
      shamt   = 5'(c + 1);
      dataIn  = 32'hA5A5_0000 + 32'(c);
      inValid = 1'b1;
      step();
    end
    inValid = 1'b0;
    waits = 0;
    while (!outValid && waits < 10) begin
      step();
      waits++;
    end
    check("pre_rst_out_valid", 64'(outValid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(outValid), 64'(0));
    check("mid_rst_data_out", 64'(dataOut), 64'(0));
    check("mid_rst_carry_out", 64'(carryOut), 64'(0));
    check("mid_rst_in_ready", 64'(inReady), 64'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    outReady = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (outValid) stale = 1'b1;
    end
    check("post_rst_no_stale", 64'(stale), 64'(0));
    check("post_rst_in_ready", 64'(inReady), 64'(1));
    run_one("post_rst_ror", SHIFT_ROR, 5'd1, 32'h0000_0003, 32'h8000_0001, 1'b1);

    // Random traffic against the scoreboard.
    pending = 1'b0;
    ops     = 0;
    for (int c = 0; c < 60000 && ops < 10000; c++) begin
      if (!pending) begin
        mode    = 3'($urandom_range(0, 7));
        shamt   = 5'($urandom_range(0, 31));
        dataIn  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        inValid = ($urandom_range(0, 4) != 0);
      end
      outReady = ($urandom_range(0, 3) != 0);
      #1;
      if (inValid && inReady) begin
        ops++;
        pending = 1'b0;
      end else begin
        pending = inValid;
      end
      step();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    check("random_ops_accepted", 64'(ops), 64'(10000));
    for (int c = 0; c < 50 && (exp_q.size() != 0 || outValid); c++) step();
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_idle", 64'(outValid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
